// File: rtl/mips_tb_instr_rom_monitor.sv
// Purpose: loadable instruction ROM with fetch wait states, plus an end-of-program monitor for the mips_cpu_harvard bench.
// Latency: LATENCY=0 gives a combinational fetch; otherwise data is registered LATENCY enabled edges after an address change.
// Backpressure: instr_wait is held high while a fetch is waiting; clk_enable=0 freezes the wait, monitor and cycle logic.
//
// Ports:
//   clk, reset            bench clock (rising edge); asynchronous active-high reset
//   clk_enable            qualifies every monitor/wait update (ROM writes ignore it)
//   instr_address         CPU fetch byte address
//   instr_readdata        instruction word returned to the CPU (0 outside the ROM)
//   instr_wait            fetch still in its wait states
//   prog_we/addr/data     ROM load port, word-indexed
//   register_v0, active   CPU debug outputs being monitored
//   expected_v0           value $v0 must hold when the halt address is fetched
//   done, pass, status    sticky result: 00 pass, 01 wrong $v0/inactive, 10 timeout, 11 address error
//   cycle_count           enabled cycles spent running, saturating
module mips_tb_instr_rom_monitor #(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter int          LATENCY      = 0,
    parameter int          MAX_CYCLES   = 1000,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    input  logic [31:0]   instr_address,
    output logic [31:0]   instr_readdata,
    output logic          instr_wait,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [31:0]   register_v0,
    input  logic          active,
    input  logic [31:0]   expected_v0,
    output logic          done,
    output logic          pass,
    output logic [1:0]    status,
    output logic [31:0]   cycle_count
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_PASS    = 2'b01,
        S_FAIL    = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    logic [31:0] mem [DEPTH];

    // ROM contents survive reset so a rerun needs no reload.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    logic [31:0]   offset;
    logic          in_range;
    logic          is_halt;
    logic [AW-1:0] idx;
    logic [31:0]   rom_word;

    assign offset   = instr_address - RESET_VECTOR;
    assign in_range = (offset[1:0] == 2'b00) && ((offset >> 2) < 32'(DEPTH));
    assign is_halt  = (instr_address == HALT_ADDR);
    assign idx      = offset[AW+1:2];
    assign rom_word = in_range ? mem[idx] : 32'h0;

    // Distinguishes the first enabled edge after reset: it forces a fresh fetch
    // and is exempt from the inactive-CPU check.
    logic   started;
    logic   addr_err;
    state_t state, state_next;
    logic [1:0] status_next;

    always_comb begin
        state_next  = state;
        status_next = status;
        if (state == S_RUN) begin
            if (is_halt) begin
                if ((register_v0 == expected_v0) && !addr_err) begin
                    state_next  = S_PASS;
                    status_next = 2'b00;
                end else begin
                    state_next  = S_FAIL;
                    status_next = addr_err ? 2'b11 : 2'b01;
                end
            end else if (!active && started) begin
                state_next  = S_FAIL;
                status_next = 2'b01;
            end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
                state_next  = S_TIMEOUT;
                status_next = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            status      <= 2'b00;
            cycle_count <= 32'd0;
            started     <= 1'b0;
            addr_err    <= 1'b0;
        end else if (clk_enable) begin
            state   <= state_next;
            status  <= status_next;
            started <= 1'b1;
            if (!in_range && !is_halt) begin
                addr_err <= 1'b1;
            end
            // The edge that leaves RUN does not count, so a timeout freezes at MAX_CYCLES-1.
            if ((state_next == S_RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    assign done = (state != S_RUN);
    assign pass = (state == S_PASS);

    generate
        if (LATENCY == 0) begin : g_comb_read
            assign instr_readdata = rom_word;
            assign instr_wait     = 1'b0;
        end else begin : g_wait_read
            localparam logic [2:0] LAT = 3'(LATENCY);

            logic [31:0] last_addr;
            logic [31:0] rd_q;
            logic [2:0]  cnt;
            logic        fetch_new;
            logic [2:0]  remaining;

            assign fetch_new = !started || (instr_address != last_addr);
            // A new address reloads the full wait; this edge already consumes one of them.
            assign remaining = fetch_new ? LAT : cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    last_addr <= 32'h0;
                    rd_q      <= 32'h0;
                    cnt       <= 3'd0;
                end else if (clk_enable) begin
                    if (fetch_new) begin
                        last_addr <= instr_address;
                    end
                    if (remaining != 3'd0) begin
                        cnt <= remaining - 3'd1;
                    end
                    if (remaining == 3'd1) begin
                        rd_q <= rom_word;
                    end
                end
            end

            assign instr_readdata = rd_q;
            assign instr_wait     = fetch_new || (cnt != 3'd0);
        end
    endgenerate

endmodule

// File: tb/tb_mips_tb_instr_rom_monitor.sv
// Purpose: directed bench for mips_tb_instr_rom_monitor across three parameter sets.
// Latency: u0/u1 combinational fetch, u2 two wait states.
// Backpressure: clk_enable is dropped mid-wait on u2 to stretch the fetch.
module tb_mips_tb_instr_rom_monitor;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [2:0]  prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] register_v0;
    logic        active;
    logic [31:0] expected_v0;

    logic [31:0] rd0, rd1, rd2;
    logic        wait0, wait1, wait2;
    logic        done0, done1, done2;
    logic        pass0, pass1, pass2;
    logic [1:0]  status0, status1, status2;
    logic [31:0] cc0, cc1, cc2;

    int checks = 0;
    int errors = 0;

    mips_tb_instr_rom_monitor #(.DEPTH(64), .LATENCY(0), .MAX_CYCLES(1000)) u0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_address(instr_address), .instr_readdata(rd0), .instr_wait(wait0),
        .prog_we(prog_we[0]), .prog_addr(prog_addr), .prog_data(prog_data),
        .register_v0(register_v0), .active(active), .expected_v0(expected_v0),
        .done(done0), .pass(pass0), .status(status0), .cycle_count(cc0)
    );

    mips_tb_instr_rom_monitor #(.DEPTH(64), .LATENCY(0), .MAX_CYCLES(64)) u1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_address(instr_address), .instr_readdata(rd1), .instr_wait(wait1),
        .prog_we(prog_we[1]), .prog_addr(prog_addr), .prog_data(prog_data),
        .register_v0(register_v0), .active(active), .expected_v0(expected_v0),
        .done(done1), .pass(pass1), .status(status1), .cycle_count(cc1)
    );

    mips_tb_instr_rom_monitor #(.DEPTH(64), .LATENCY(2), .MAX_CYCLES(1000)) u2 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_address(instr_address), .instr_readdata(rd2), .instr_wait(wait2),
        .prog_we(prog_we[2]), .prog_addr(prog_addr), .prog_data(prog_data),
        .register_v0(register_v0), .active(active), .expected_v0(expected_v0),
        .done(done2), .pass(pass2), .status(status2), .cycle_count(cc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] mask, input logic [5:0] a, input logic [31:0] d);
        prog_we   = mask;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // One fetch on u0: present the address, check the combinational word, take an edge.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] w);
        instr_address = a;
        #1;
        chk(tag, rd0, w);
        tick();
    endtask

    task automatic run_prog(input logic [31:0] v0_at_halt);
        fetch("fetch_w0", 32'hBFC00000, 32'h24A50009);
        fetch("fetch_w1", 32'hBFC00004, 32'h00A51021);
        fetch("fetch_w2", 32'hBFC00008, 32'h00000008);
        fetch("fetch_w3", 32'hBFC0000C, 32'h24000000);
        instr_address = 32'h00000000;
        register_v0   = v0_at_halt;
        tick();
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        clk_enable    = 1'b1;
        active        = 1'b1;
        instr_address = 32'hBFC00000;
        register_v0   = 32'd0;
        expected_v0   = 32'd18;
        prog_we       = 3'b000;
        prog_addr     = 6'd0;
        prog_data     = 32'd0;

        // ROM loads during reset; u1 gets the self-loop program.
        write_word(3'b101, 6'd0, 32'h24A50009);
        write_word(3'b101, 6'd1, 32'h00A51021);
        write_word(3'b101, 6'd2, 32'h00000008);
        write_word(3'b101, 6'd3, 32'h24000000);
        write_word(3'b010, 6'd0, 32'h1000FFFF);

        @(negedge clk);
        chk("rst_done",   32'(done0), 32'd0);
        chk("rst_pass",   32'(pass0), 32'd0);
        chk("rst_status", 32'(status0), 32'd0);
        chk("rst_cycles", cc0, 32'd0);
        chk("rst_wait_l0", 32'(wait0), 32'd0);
        chk("rst_wait_l2", 32'(wait2), 32'd1);
        chk("rst_rd_l2",  rd2, 32'd0);
        reset = 1'b0;

        // Correct $v0 at halt.
        run_prog(32'd18);
        chk("t1_done",   32'(done0), 32'd1);
        chk("t1_pass",   32'(pass0), 32'd1);
        chk("t1_status", 32'(status0), 32'd0);
        chk("t1_cycles", cc0, 32'd4);

        // Wrong expected value; result must be sticky.
        do_reset();
        expected_v0 = 32'd17;
        run_prog(32'd18);
        chk("t2_done",   32'(done0), 32'd1);
        chk("t2_pass",   32'(pass0), 32'd0);
        chk("t2_status", 32'(status0), 32'd1);
        instr_address = 32'hBFC00000;
        repeat (20) tick();
        chk("t2_hold_done",   32'(done0), 32'd1);
        chk("t2_hold_pass",   32'(pass0), 32'd0);
        chk("t2_hold_status", 32'(status0), 32'd1);
        chk("t2_hold_cycles", cc0, 32'd4);
        reset = 1'b1;
        #1;
        chk("t2_arst_done",   32'(done0), 32'd0);
        chk("t2_arst_status", 32'(status0), 32'd0);
        reset = 1'b0;

        // Reset mid-run, then rerun without reloading the ROM.
        do_reset();
        expected_v0   = 32'd18;
        instr_address = 32'hBFC00000;
        repeat (10) tick();
        chk("t6_cycles_before", cc0, 32'd10);
        reset = 1'b1;
        #1;
        chk("t6_arst_cycles", cc0, 32'd0);
        chk("t6_arst_done",   32'(done0), 32'd0);
        reset = 1'b0;
        run_prog(32'd18);
        chk("t6_rerun_pass", 32'(pass0), 32'd1);
        chk("t6_rerun_done", 32'(done0), 32'd1);

        // Inactive CPU: first edge is exempt, the second one fails.
        do_reset();
        instr_address = 32'hBFC00000;
        active = 1'b0;
        tick();
        chk("inact_first_done", 32'(done0), 32'd0);
        tick();
        chk("inact_done",   32'(done0), 32'd1);
        chk("inact_status", 32'(status0), 32'd1);
        active = 1'b1;

        // Timeout on u1 (MAX_CYCLES=64).
        do_reset();
        instr_address = 32'hBFC00000;
        #1;
        chk("t3_loop_word", rd1, 32'h1000FFFF);
        n = 0;
        while (!done1 && n < 200) begin
            tick();
            n++;
        end
        chk("t3_edges",  32'(n), 32'd64);
        chk("t3_status", 32'(status1), 32'd2);
        chk("t3_done",   32'(done1), 32'd1);
        chk("t3_pass",   32'(pass1), 32'd0);
        chk("t3_cycles", cc1, 32'd63);

        // Out-of-range fetch, then a halt with the right $v0.
        do_reset();
        expected_v0 = 32'd18;
        fetch("t5_oor_word", 32'hBFC00100, 32'h00000000);
        instr_address = 32'h00000000;
        register_v0   = 32'd18;
        tick();
        chk("t5_status", 32'(status0), 32'd3);
        chk("t5_pass",   32'(pass0), 32'd0);
        chk("t5_done",   32'(done0), 32'd1);

        // Wait states on u2 (LATENCY=2), with a clock-enable stall mid-wait.
        instr_address = 32'hBFC00000;
        do_reset();
        #1;
        chk("t4_wait_r",  32'(wait2), 32'd1);
        chk("t4_rd_r",    rd2, 32'd0);
        tick();
        chk("t4_wait_e1", 32'(wait2), 32'd1);
        chk("t4_rd_e1",   rd2, 32'd0);
        tick();
        chk("t4_wait_e2", 32'(wait2), 32'd0);
        chk("t4_rd_e2",   rd2, 32'h24A50009);
        instr_address = 32'hBFC00004;
        #1;
        chk("t4_wait_chg", 32'(wait2), 32'd1);
        chk("t4_rd_chg",   rd2, 32'h24A50009);
        tick();
        chk("t4_wait_b1",  32'(wait2), 32'd1);
        clk_enable = 1'b0;
        repeat (3) tick();
        chk("t4_wait_stall", 32'(wait2), 32'd1);
        chk("t4_rd_stall",   rd2, 32'h24A50009);
        clk_enable = 1'b1;
        tick();
        chk("t4_wait_b2", 32'(wait2), 32'd0);
        chk("t4_rd_b2",   rd2, 32'h00A51021);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
